// File: rtl/serial_pkg.sv
// serial_pkg: types and constants shared by the serial transmitter and receiver.
// Rev 1.0
`default_nettype none

package serial_pkg;

  localparam int c_DEFAULT_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rx_shift_core.sv
// rx_shift_core: WIDTH-bit receive shift register with direction select and clear-and-load.
// Rev 1.0
`default_nettype none

module rx_shift_core
  import serial_pkg::*;
#(
  parameter int WIDTH     = c_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_word_next
);

  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_shift_val;

  // The completed word is taken from o_word_next so the final bit is included.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_load_val  = {{(WIDTH-1){1'b0}}, i_bit};
      assign w_shift_val = {r_word[WIDTH-2:0], i_bit};
    end else begin : g_lsb
      assign w_load_val  = {i_bit, {(WIDTH-1){1'b0}}};
      assign w_shift_val = {i_bit, r_word[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    o_word_next = r_word;
    if (i_load) begin
      o_word_next = w_load_val;
    end else if (i_shift) begin
      o_word_next = w_shift_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word <= '0;
    end else begin
      r_word <= o_word_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_byte_rx.sv
// serial_byte_rx: sof-framed serial-to-parallel receiver with one-entry valid/ready holding register.
// Rev 1.0
`default_nettype none

module serial_byte_rx
  import serial_pkg::*;
#(
  parameter int WIDTH     = c_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_abort,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int c_CW = $clog2(WIDTH + 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [c_CW-1:0]   r_count;
  logic [c_CW-1:0]   w_count_next;
  logic              w_complete;
  logic              w_sof;
  logic              w_take;
  logic              w_load;
  logic              w_drop;
  logic [WIDTH-1:0]  w_word_next;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_valid;
  logic              r_overflow;
  logic              r_abort;

  assign w_sof  = bit_valid & sof;
  assign w_take = bit_valid & ~sof & (r_state == SHIFT);

  rx_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_sof),
    .i_shift     (w_take),
    .i_bit       (serial_in),
    .o_word_next (w_word_next)
  );

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sof) begin
          w_state_next = SHIFT;
          w_count_next = c_CW'(1);
        end
      end
      SHIFT: begin
        if (w_sof) begin
          w_count_next = c_CW'(1);
        end else if (w_take) begin
          if (r_count == c_CW'(WIDTH - 1)) begin
            w_state_next = IDLE;
            w_count_next = '0;
            w_complete   = 1'b1;
          end else begin
            w_count_next = r_count + c_CW'(1);
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  // A word may enter the holding register when it is empty or being drained this cycle.
  assign w_load = w_complete & (~r_out_valid | out_ready);
  assign w_drop = w_complete & r_out_valid & ~out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_abort <= w_sof & (r_state == SHIFT);
      if (w_load) begin
        r_out_data  <= w_word_next;
        r_out_valid <= 1'b1;
      end else if (r_out_valid & out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign overflow    = r_overflow;
  assign frame_abort = r_abort;
  assign busy        = (r_state == SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_serial_byte_rx.sv
// tb_serial_byte_rx: directed checks of serial_byte_rx, MSB-first and LSB-first instances side by side.
// Rev 1.0
`default_nettype none

module tb_serial_byte_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       sof = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       ready_m = 1'b1;
  logic       ready_l = 1'b1;
  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l, busy_m, busy_l;
  logic       abort_m, abort_l, ovf_m, ovf_l;

  int vectors = 0;
  int miscompares = 0;
  int abort_cnt = 0;
  int bubble_cnt = 0;
  bit bubble_en = 1'b0;

  always #5 clk = ~clk;

  serial_byte_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_m (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid), .sof(sof),
    .out_data(data_m), .out_valid(valid_m), .out_ready(ready_m), .busy(busy_m),
    .frame_abort(abort_m), .overflow(ovf_m), .clr_ovf(clr_ovf)
  );

  serial_byte_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_l (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid), .sof(sof),
    .out_data(data_l), .out_valid(valid_l), .out_ready(ready_l), .busy(busy_l),
    .frame_abort(abort_l), .overflow(ovf_l), .clr_ovf(clr_ovf)
  );

  always @(negedge clk) begin
    if (abort_m) abort_cnt++;
    if (bubble_en && !valid_m) bubble_cnt++;
  end

  // Sends v[7] first; sof on the first bit, gap idle cycles between bits,
  // optionally raising ready_m together with the last bit. Returns one cycle after the last bit edge.
  task automatic send_frame(input logic [7:0] v, input int n, input int gap, input bit rl);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if (busy_m !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_in_frame bit %0d: got %b want 1", i, busy_m);
        end
      end
      bit_valid = 1'b1;
      serial_in = v[7-i];
      sof       = (i == 0);
      if (rl && i == n - 1) ready_m = 1'b1;
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          bit_valid = 1'b0;
          sof       = 1'b0;
        end
      end
    end
    @(negedge clk);
    bit_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    vectors++;
    if ({data_m, valid_m, busy_m, abort_m, ovf_m} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_m: got data=%h v=%b b=%b a=%b o=%b want all 0", data_m, valid_m, busy_m, abort_m, ovf_m);
    end
    vectors++;
    if ({data_l, valid_l, busy_l, abort_l, ovf_l} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_l: got data=%h v=%b b=%b a=%b o=%b want all 0", data_l, valid_l, busy_l, abort_l, ovf_l);
    end
  endtask

  task automatic test_basic();
    ready_m   = 1'b1;
    abort_cnt = 0;
    send_frame(8'hA5, 8, 0, 1'b0);
    vectors++;
    if (valid_m !== 1'b1 || data_m !== 8'hA5) begin
      miscompares++;
      $display("FAIL a5_msb: got v=%b data=%h want v=1 data=a5", valid_m, data_m);
    end
    vectors++;
    if (valid_l !== 1'b1 || data_l !== 8'hA5) begin
      miscompares++;
      $display("FAIL a5_lsb: got v=%b data=%h want v=1 data=a5", valid_l, data_l);
    end
    vectors++;
    if (busy_m !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_frame: got %b want 0", busy_m);
    end
    @(negedge clk);
    vectors++;
    if (valid_m !== 1'b0 || data_m !== 8'hA5) begin
      miscompares++;
      $display("FAIL a5_drain: got v=%b data=%h want v=0 data=a5", valid_m, data_m);
    end
    vectors++;
    if (abort_cnt !== 0) begin
      miscompares++;
      $display("FAIL a5_no_abort: got %0d pulses want 0", abort_cnt);
    end
    send_frame(8'h01, 8, 0, 1'b0);
    vectors++;
    if (data_l !== 8'h80 || data_m !== 8'h01) begin
      miscompares++;
      $display("FAIL x01_order: got lsb=%h msb=%h want lsb=80 msb=01", data_l, data_m);
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    ready_m = 1'b0;
    send_frame(8'h3C, 8, 0, 1'b0);
    vectors++;
    if (valid_m !== 1'b1 || data_m !== 8'h3C || ovf_m !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_first: got v=%b data=%h o=%b want v=1 data=3c o=0", valid_m, data_m, ovf_m);
    end
    send_frame(8'hC3, 8, 0, 1'b0);
    vectors++;
    if (valid_m !== 1'b1 || data_m !== 8'h3C || ovf_m !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_drop: got v=%b data=%h o=%b want v=1 data=3c o=1", valid_m, data_m, ovf_m);
    end
    vectors++;
    if (data_l !== 8'hC3 || ovf_l !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_lsb_ready: got data=%h o=%b want data=c3 o=0", data_l, ovf_l);
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    ready_m = 1'b1;
    vectors++;
    if (ovf_m !== 1'b0 || valid_m !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_clear: got o=%b v=%b want o=0 v=1", ovf_m, valid_m);
    end
    @(negedge clk);
    vectors++;
    if (valid_m !== 1'b0 || data_m !== 8'h3C) begin
      miscompares++;
      $display("FAIL ovf_drain: got v=%b data=%h want v=0 data=3c", valid_m, data_m);
    end
  endtask

  task automatic test_abort();
    ready_m   = 1'b1;
    send_frame(8'hF0, 4, 0, 1'b0);
    abort_cnt = 0;
    send_frame(8'h5A, 8, 0, 1'b0);
    vectors++;
    if (abort_cnt !== 1 || abort_m !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_pulse: got %0d pulses (now %b) want 1 (now 0)", abort_cnt, abort_m);
    end
    vectors++;
    if (valid_m !== 1'b1 || data_m !== 8'h5A || data_l !== 8'h5A) begin
      miscompares++;
      $display("FAIL abort_word: got v=%b msb=%h lsb=%h want v=1 5a 5a", valid_m, data_m, data_l);
    end
  endtask

  task automatic test_back_to_back();
    for (int gap = 0; gap <= 2; gap += 2) begin
      @(negedge clk);
      ready_m = 1'b0;
      send_frame(8'h11, 8, 0, 1'b0);
      vectors++;
      if (valid_m !== 1'b1 || data_m !== 8'h11) begin
        miscompares++;
        $display("FAIL hold_11 gap %0d: got v=%b data=%h want v=1 data=11", gap, valid_m, data_m);
      end
      bubble_cnt = 0;
      bubble_en  = 1'b1;
      send_frame(8'h22, 8, gap, 1'b1);
      bubble_en  = 1'b0;
      vectors++;
      if (valid_m !== 1'b1 || data_m !== 8'h22 || bubble_cnt !== 0) begin
        miscompares++;
        $display("FAIL no_bubble gap %0d: got v=%b data=%h bubbles=%0d want v=1 data=22 bubbles=0",
                 gap, valid_m, data_m, bubble_cnt);
      end
      vectors++;
      if (ovf_m !== 1'b0 || data_l !== 8'h44) begin
        miscompares++;
        $display("FAIL b2b_side gap %0d: got o=%b lsb=%h want o=0 lsb=44", gap, ovf_m, data_l);
      end
    end
  endtask

  task automatic test_reset_mid();
    ready_m = 1'b0;
    send_frame(8'hFF, 5, 0, 1'b0);
    vectors++;
    if (busy_m !== 1'b1 || valid_m !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: got b=%b v=%b want b=1 v=1", busy_m, valid_m);
    end
    abort_cnt = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++;
    if (busy_m !== 1'b0 || valid_m !== 1'b0 || data_m !== 8'h00 || abort_cnt !== 0) begin
      miscompares++;
      $display("FAIL mid_reset: got b=%b v=%b data=%h aborts=%0d want 0 0 00 0", busy_m, valid_m, data_m, abort_cnt);
    end
    ready_m = 1'b1;
    send_frame(8'h7E, 8, 0, 1'b0);
    vectors++;
    if (valid_m !== 1'b1 || data_m !== 8'h7E || data_l !== 8'h7E || abort_cnt !== 0) begin
      miscompares++;
      $display("FAIL after_reset_7e: got v=%b msb=%h lsb=%h aborts=%0d want 1 7e 7e 0",
               valid_m, data_m, data_l, abort_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
